// File: rtl/seven_seg_scan_decoder.sv
// Samples a scanned active-low 7-seg bus and rebuilds the displayed BCD frame.
// Optional watchdog: define SEVSEG_DEC_TIMEOUT_EN.
module seven_seg_scan_decoder #(
   parameter int         STABLE_CYC  = 16,
   parameter logic [7:0] DIGIT_MASK  = 8'hFF,
   parameter int         TIMEOUT_CYC = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  an_in,
   input  logic [6:0]  seg_in,
   output logic [31:0] digits,
   output logic [7:0]  digit_err,
   output logic        frame_valid,
   output logic        timeout
);

   localparam int CW = $clog2(STABLE_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

   typedef enum logic [1:0] {SCAN, SETTLE, HOLD} state_t;

   state_t         state;
   logic [7:0]     an_m, s_an, ref_an;
   logic [6:0]     seg_m, s_seg, ref_seg;
   logic [CW-1:0]  cnt;
   logic [7:0]     seen, seen_nxt, cap_oh;
   logic [7:0][3:0] stage_nib;
   logic [7:0]     stage_err;
   logic [2:0]     cap_idx;
   logic [4:0]     dec;
   logic           one_cold, same, cap, complete, wd_fire;

   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'b1000000: r = 5'h00;
         7'b1111001: r = 5'h01;
         7'b0100100: r = 5'h02;
         7'b0110000: r = 5'h03;
         7'b0011001: r = 5'h04;
         7'b0010010: r = 5'h05;
         7'b0000010: r = 5'h06;
         7'b1111000: r = 5'h07;
         7'b0000000: r = 5'h08;
         7'b0010000: r = 5'h09;
         7'b1111111: r = 5'h0F;
         default:    r = 5'h1E;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_m  <= '1;
         s_an  <= '1;
         seg_m <= '1;
         s_seg <= '1;
      end else begin
         an_m  <= an_in;
         s_an  <= an_m;
         seg_m <= seg_in;
         s_seg <= seg_m;
      end
   end

   always_comb begin
      one_cold = (~s_an != 8'h00) && (((~s_an) & (~s_an - 8'd1)) == 8'h00);
      same     = (s_an == ref_an) && (s_seg == ref_seg);
      cap      = (state == SETTLE) && same && (cnt == CNT_LAST);
      cap_idx  = 3'd0;
      for (int i = 0; i < 8; i++)
         if (!s_an[i]) cap_idx = 3'(i);
      cap_oh   = cap ? (8'd1 << cap_idx) : 8'h00;
      dec      = decode(s_seg);
      complete = ((seen & DIGIT_MASK) == DIGIT_MASK);
      seen_nxt = ((complete || wd_fire) ? 8'h00 : seen) | cap_oh;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= SCAN;
         ref_an  <= '1;
         ref_seg <= '1;
         cnt     <= '0;
      end else begin
         unique case (state)
            SCAN: if (one_cold) begin
               ref_an  <= s_an;
               ref_seg <= s_seg;
               cnt     <= CW'(1);
               state   <= SETTLE;
            end
            SETTLE: if (same) begin
               if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
               if (cap) state <= HOLD;
            end else if (one_cold) begin
               ref_an  <= s_an;
               ref_seg <= s_seg;
               cnt     <= CW'(1);
            end else begin
               state <= SCAN;
            end
            // An anode change is handled like SCAN in the same cycle.
            HOLD: if (s_an != ref_an) begin
               if (one_cold) begin
                  ref_an  <= s_an;
                  ref_seg <= s_seg;
                  cnt     <= CW'(1);
                  state   <= SETTLE;
               end else begin
                  state <= SCAN;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seen        <= '0;
         stage_nib   <= {8{4'hF}};
         stage_err   <= '0;
         digits      <= 32'hFFFF_FFFF;
         digit_err   <= '0;
         frame_valid <= 1'b0;
      end else begin
         seen        <= seen_nxt;
         frame_valid <= complete;
         if (cap) begin
            stage_nib[cap_idx] <= dec[3:0];
            stage_err[cap_idx] <= dec[4];
         end
         if (complete) begin
            for (int i = 0; i < 8; i++) begin
               digits[4*i +: 4] <= DIGIT_MASK[i] ? stage_nib[i] : 4'hF;
               digit_err[i]     <= DIGIT_MASK[i] & stage_err[i];
            end
         end
      end
   end

`ifdef SEVSEG_DEC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] wd;

   assign wd_fire = !cap && (wd == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd      <= '0;
         timeout <= 1'b0;
      end else if (cap) begin
         wd <= '0;
      end else if (wd_fire) begin
         wd      <= '0;
         timeout <= 1'b1;
      end else begin
         wd <= wd + 1'b1;
      end
   end
`else
   assign wd_fire = 1'b0;
   assign timeout = 1'b0;
`endif

endmodule
